ecc_core_arbiter: RTL and testbench

//  Shares the single ECC scalar-multiply core between two requesters:

---
 rtl/ecc_core_arbiter_pkg.sv | 16 +
 rtl/ecc_core_arbiter_if.sv | 15 +
 rtl/ecc_core_arbiter_rr_pick.sv | 17 +
 rtl/ecc_core_arbiter.sv | 118 +++++++++++
 tb/tb_ecc_core_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_core_arbiter_pkg.sv
// Shared types for the ECC core arbiter: coordinate width, FSM states and requester id.
package eccdh_pkg;

  localparam int ECC_W = 164;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPT,
    DONE
  } arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/ecc_core_arbiter_if.sv
// Arbiter-to-core bus: scalar and start toward the core, completion and result point back.
interface ecc_core_arbiter_if
  import eccdh_pkg::*;
#(
  parameter int W = ECC_W
);
  logic [W-1:0] ecc_k;
  logic         estart;
  logic         edone;
  logic [W-1:0] Pox;
  logic [W-1:0] Poy;

  modport master (output ecc_k, estart, input edone, Pox, Poy);
  modport slave  (input ecc_k, estart, output edone, Pox, Poy);
endinterface

// File: rtl/ecc_core_arbiter_rr_pick.sv
// Two-way round-robin picker: on a tie the requester that was not served last wins.
module ecc_rr_pick
  import eccdh_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic       valid,
  output req_id_t    id
);

  always_comb begin
    valid = |req;
    if (&req) id = ~last;
    else      id = req[1];
  end

endmodule

// File: rtl/ecc_core_arbiter.sv
// Shares one ECC scalar-multiply core between two requesters (round-robin).
// Optional watchdog abort of a stuck RUN is built only when ARB_WATCHDOG_EN is defined.
module ecc_core_arbiter
  import eccdh_pkg::*;
#(
  parameter int ECC_W       = eccdh_pkg::ECC_W,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [ECC_W-1:0]   k0,
  input  logic [ECC_W-1:0]   k1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [ECC_W-1:0]   res_x,
  output logic [ECC_W-1:0]   res_y,
  output logic               busy,
  output logic               err,
  ecc_core_arbiter_if.master core
);

  arb_state_t       state, state_n;
  req_id_t          owner, owner_n, last;
  logic             pick_valid;
  req_id_t          pick_id;
  logic             timeout;
  logic             estart_q, done_en;
  logic [ECC_W-1:0] ecc_k_q;

  ecc_rr_pick u_pick (
    .req   ({req1, req0}),
    .last  (last),
    .valid (pick_valid),
    .id    (pick_id)
  );

`ifdef ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        err_q;
  assign timeout = (wd_cnt == 16'(TIMEOUT_CYC - 1));
  assign err     = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign timeout    = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_n = state;
    owner_n = owner;
    case (state)
      IDLE: if (pick_valid) begin
        state_n = LOAD;
        owner_n = pick_id;
      end
      LOAD: state_n = RUN;
      RUN: begin
        if (core.edone)   state_n = CAPT;
        else if (timeout) state_n = IDLE;
      end
      CAPT:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      estart_q <= 1'b0;
      done_en  <= 1'b0;
      ecc_k_q  <= '0;
      res_x    <= '0;
      res_y    <= '0;
`ifdef ARB_WATCHDOG_EN
      wd_cnt   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      // Outputs are registered from the next state so they line up with it exactly.
      gnt0     <= (state_n != IDLE) && (owner_n == 1'b0);
      gnt1     <= (state_n != IDLE) && (owner_n == 1'b1);
      busy     <= (state_n != IDLE);
      estart_q <= (state_n == RUN);
      done_en  <= (state_n == DONE);
      if (state == LOAD) ecc_k_q <= owner ? k1 : k0;
      // Pox/Poy are only guaranteed in the edone cycle, so capture on entry to CAPT.
      if (state == RUN && core.edone) begin
        res_x <= core.Pox;
        res_y <= core.Poy;
      end
      if (state == CAPT || (state == RUN && state_n == IDLE)) last <= owner;
`ifdef ARB_WATCHDOG_EN
      if (state == LOAD)     wd_cnt <= '0;
      else if (state == RUN) wd_cnt <= wd_cnt + 16'd1;
      err_q <= (state == RUN) && (state_n == IDLE);
`endif
    end
  end

  assign core.ecc_k  = ecc_k_q;
  assign core.estart = estart_q;
  assign done0       = done_en && (owner == 1'b0) && req0;
  assign done1       = done_en && (owner == 1'b1) && req1;

endmodule

// File: tb/tb_ecc_core_arbiter.sv
// Directed bench for ecc_core_arbiter with a fixed-latency core model.
// Watchdog scenario is compiled in only when ARB_WATCHDOG_EN is defined.
module tb_ecc_core_arbiter;
  import eccdh_pkg::*;

  localparam int W = ECC_W;
`ifdef ARB_WATCHDOG_EN
  localparam int TO = 20;
`else
  localparam int TO = 65535;
`endif

  logic         clk = 1'b0;
  logic         n_rst, req0, req1;
  logic [W-1:0] k0, k1, res_x, res_y;
  logic         gnt0, gnt1, done0, done1, busy, err;

  int n_chk = 0, n_fail = 0;
  int m_cnt = 0;
  bit core_en = 1'b1;
  int overlap = 0, stray_done = 0;

  ecc_core_arbiter_if core_if ();

  ecc_core_arbiter #(.ECC_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .req0  (req0),
    .req1  (req1),
    .k0    (k0),
    .k1    (k1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .res_x (res_x),
    .res_y (res_y),
    .busy  (busy),
    .err   (err),
    .core  (core_if)
  );

  always #5 clk = ~clk;

  // Core model: edone pulses 10 cycles after estart rises; result derived from the scalar.
  always @(posedge clk) begin
    if (!core_if.estart) begin
      m_cnt        <= 0;
      core_if.edone <= 1'b0;
    end else begin
      m_cnt        <= m_cnt + 1;
      core_if.edone <= core_en && (m_cnt == 9);
    end
  end
  assign core_if.Pox = core_if.ecc_k + W'(100);
  assign core_if.Poy = core_if.ecc_k ^ W'(164'h5a5a_5a5a_5a5a);

  always @(negedge clk) begin
    if (gnt0 && gnt1) overlap <= overlap + 1;
    if ((done0 && !gnt0) || (done1 && !gnt1)) stray_done <= stray_done + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] px(input logic [W-1:0] k);
    return k + W'(100);
  endfunction
  function automatic logic [W-1:0] py(input logic [W-1:0] k);
    return k ^ W'(164'h5a5a_5a5a_5a5a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk_eq({tag, "_gnt"}, {gnt1, gnt0}, 0);
    chk_eq({tag, "_done"}, {done1, done0}, 0);
    chk_eq({tag, "_res_x"}, res_x, 0);
    chk_eq({tag, "_res_y"}, res_y, 0);
    chk_eq({tag, "_ecc_k"}, core_if.ecc_k, 0);
    chk_eq({tag, "_estart"}, core_if.estart, 0);
    chk_eq({tag, "_busy"}, busy, 0);
    chk_eq({tag, "_err"}, err, 0);
  endtask

  task automatic wait_gnt(input int who);
    for (int i = 0; i < 40; i++) begin
      if ((who == 0) ? gnt0 : gnt1) break;
      tick();
    end
    chk_eq($sformatf("gnt%0d_seen", who), (who == 0) ? gnt0 : gnt1, 1);
  endtask

  task automatic wait_estart();
    for (int i = 0; i < 10; i++) begin
      if (core_if.estart) break;
      tick();
    end
    chk_eq("estart_seen", core_if.estart, 1);
  endtask

  task automatic wait_edone();
    for (int i = 0; i < 100; i++) begin
      if (core_if.edone) break;
      tick();
    end
    chk_eq("edone_seen", core_if.edone, 1);
  endtask

  // Serve one full operation for requester 'who'; ends in the DONE cycle.
  task automatic serve(input int who, input logic [W-1:0] k, input bit drop);
    wait_gnt(who);
    wait_estart();
    chk_eq($sformatf("ecc_k%0d", who), core_if.ecc_k, k);
    wait_edone();
    tick();
    chk_eq($sformatf("done%0d_early", who), (who == 0) ? done0 : done1, 0);
    chk_eq($sformatf("res_x%0d", who), res_x, px(k));
    tick();
    chk_eq($sformatf("done%0d", who), (who == 0) ? done0 : done1, 1);
    chk_eq($sformatf("gnt%0d_at_done", who), (who == 0) ? gnt0 : gnt1, 1);
    chk_eq($sformatf("res_y%0d", who), res_y, py(k));
    if (drop) begin
      if (who == 0) req0 = 1'b0;
      else          req1 = 1'b0;
    end
  endtask

  initial begin
    int cnt;
    n_rst = 1'b0; req0 = 1'b0; req1 = 1'b0; k0 = '0; k1 = '0;
    tick();
    tick();
    chk_reset("rst");
    n_rst = 1'b1;
    tick();

    // 1: single request, latency checks
    k0 = W'(5); req0 = 1'b1;
    tick();
    chk_eq("t1_gnt0_load", gnt0, 1);
    chk_eq("t1_estart_load", core_if.estart, 0);
    chk_eq("t1_busy", busy, 1);
    tick();
    chk_eq("t1_estart_run", core_if.estart, 1);
    chk_eq("t1_ecc_k", core_if.ecc_k, W'(5));
    wait_edone();
    tick();
    chk_eq("t1_done0_capt", done0, 0);
    tick();
    chk_eq("t1_done0", done0, 1);
    chk_eq("t1_res_x", res_x, W'(105));
    req0 = 1'b0;
    tick();
    chk_eq("t1_idle_busy", busy, 0);
    chk_eq("t1_done0_off", done0, 0);

    // 2: simultaneous requests after reset, req0 first
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    k0 = W'(164'h1234_5678); k1 = W'(164'hdead_beef_0001);
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk_eq("t2_first_gnt", {gnt1, gnt0}, 2'b01);
    serve(0, k0, 1'b1);
    serve(1, k1, 1'b1);
    tick();
    chk_eq("t2_idle_busy", busy, 0);

    // 3: both held, grants alternate 0,1,0
    k0 = W'(164'h77); k1 = W'(164'h88);
    req0 = 1'b1; req1 = 1'b1;
    serve(0, k0, 1'b0);
    serve(1, k1, 1'b0);
    serve(0, k0, 1'b1);
    req1 = 1'b0;
    tick();
    chk_eq("t3_idle_busy", busy, 0);

    // 4: owner withdraws mid-run
    k1 = W'(164'h4_0000_0000_0000_0042);
    req1 = 1'b1;
    wait_gnt(1);
    wait_estart();
    tick(); tick(); tick();
    req1 = 1'b0;
    wait_edone();
    tick();
    chk_eq("t4_res_x", res_x, px(k1));
    tick();
    chk_eq("t4_done1", done1, 0);
    chk_eq("t4_gnt1", gnt1, 1);
    tick();
    chk_eq("t4_idle_busy", busy, 0);
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk_eq("t4_tie_gnt", {gnt1, gnt0}, 2'b01);
    serve(0, k0, 1'b1);
    req1 = 1'b0;
    tick();

    // 5: reset during RUN
    req0 = 1'b1;
    wait_estart();
    tick(); tick();
    n_rst = 1'b0;
    tick();
    chk_reset("t5");
    n_rst = 1'b1; req0 = 1'b0;
    tick();

`ifdef ARB_WATCHDOG_EN
    // 6: core never completes, watchdog aborts after TO RUN cycles
    core_en = 1'b0;
    k0 = W'(164'h99);
    req0 = 1'b1;
    wait_estart();
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!core_if.estart) break;
      cnt++;
    end
    chk_eq("t6_run_cycles", W'(cnt), W'(TO));
    chk_eq("t6_err", err, 1);
    chk_eq("t6_busy", busy, 0);
    chk_eq("t6_done0", done0, 0);
    chk_eq("t6_res_x", res_x, 0);
    req0 = 1'b0;
    tick();
    chk_eq("t6_err_pulse", err, 0);
    core_en = 1'b1;
`endif

    chk_eq("gnt_overlap", W'(overlap), 0);
    chk_eq("done_without_gnt", W'(stray_done), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
